agc_timer_bank: RTL and testbench
=================================

// Module: agc_timer_bank
// PURPOSE
//  Parametrised bank of NUM_TIMERS up-counting WIDTH-bit timers, generalising the TIME1/TIME2 registers.
//  Has a shared prescaler and optional overflow cascading (timer i-1 overflow -> timer i increment).
//  Has per-timer sticky interrupt requests with acknowledge, and one CPU read/write port with write forwarding.
//  Sits beside register_file; the execute stage accesses timers through rd/wr ports, irq_pending feeds the interrupt unit.
// PARAMETERS
//  NUM_TIMERS    4          number of timers (>=2)
//  WIDTH         15         bits per timer (AGC word)
//  PRESCALE      8          enabled clk cycles per tick (>=1)
//  CASCADE_MASK  4'b0010    bit i=1: timer i counts timer i-1 overflows, not ticks (bit 0 ignored)
//  IRQ_MASK      4'b1100    bit i=1: timer i overflow sets irq_pending[i]
// PORTS
//  clk          in   1                  clock
//  rst_l        in   1                  asynchronous active-low reset
//  en           in   1                  prescaler run enable
//  wr_en        in   1                  CPU write strobe
//  wr_sel       in   $clog2(NUM_TIMERS) timer to write
//  wr_data      in   WIDTH              write value
//  rd_sel       in   $clog2(NUM_TIMERS) timer to read
//  rd_data      out  WIDTH              read value (combinational)
//  irq_ack      in   NUM_TIMERS         per-timer pending-clear strobes
//  tick         out  1                  registered prescaler tick pulse
//  overflow     out  NUM_TIMERS         registered 1-cycle wrap pulses
//  irq_pending  out  NUM_TIMERS         sticky interrupt requests
// BEHAVIOUR
//  Reset: all timers, prescaler, tick, overflow, irq_pending = 0; takes effect immediately, mid-count included.
//  Prescaler: counts 0..PRESCALE-1 only while en=1.
//   - At PRESCALE-1 with en=1: wraps to 0; tick=1 the next cycle.
//   - en=0: count holds; no new tick.
//   - PRESCALE=1: tick=1 in every cycle after an en=1 cycle.
//  Increment source for timer i:
//   - CASCADE_MASK[i]=1 and i>0: overflow[i-1].
//   - otherwise: tick.
//  A timer increments by 1 in any cycle its source is 1, regardless of en.
//  Cascade latency: 1 cycle per stage, because overflow[i-1] is registered.
//  Width: modulo 2^WIDTH. At all-ones, an increment wraps to 0 and overflow[i]=1 in the following cycle.
//  CPU write: wr_en loads timer[wr_sel]=wr_data.
//   - Write beats a same-cycle increment; that increment is lost and no overflow is produced.
//   - wr_sel >= NUM_TIMERS: write ignored.
//  Read: rd_data = timer[rd_sel].
//   - wr_en && wr_sel==rd_sel: rd_data = wr_data (forwarded).
//   - rd_sel >= NUM_TIMERS: rd_data = 0.
//  IRQ: overflow[i] && IRQ_MASK[i] sets irq_pending[i] on the next edge.
//   - irq_ack[i] clears irq_pending[i].
//   - Set and ack in the same cycle: set wins, stays 1.
//   - Ack while not pending: no effect.
//   - Masked timers never set pending.
//  Simultaneous events: all timers update independently in the same cycle; no priority between timers.
//  No state machine beyond prescaler and timers; every state element is a flop on clk/rst_l.
// TESTING
//  1. Defaults, en=1 for 24 cycles -> tick pulses at cycles 8, 16, 24; timer0 = 3, timer1 = 0.
//  2. Write timer0=15'h7FFF, hold en until the next tick -> timer0 = 0.
//     Then overflow[0]=1 for one cycle, timer1 increments 1 cycle later, irq_pending unchanged.
//  3. Write timer2=15'h7FFF, tick -> timer2 = 0, overflow[2]=1, irq_pending[2]=1.
//     Assert irq_ack[2] with a same-cycle new overflow -> pending stays 1; ack alone -> 0.
//  4. wr_en, wr_sel=0, wr_data=15'h1234 in a tick cycle -> timer0 = 15'h1234, not 15'h1235.
//     rd_sel=0 the same cycle -> rd_data = 15'h1234 (forwarded).
//  5. en=0 for 20 cycles mid-count -> prescaler and timers frozen; en=1 resumes from the held count.
//  6. rst_l=0 pulse mid-count with pending irq -> all outputs 0 asynchronously; counting restarts from 0.

Source files
------------

// File: rtl/agc_timer_bank.sv
// Bank of NUM_TIMERS up-counting WIDTH-bit timers with a shared prescaler, optional
// overflow cascading, sticky masked interrupt requests and one forwarding CPU port.
module agc_timer_bank #(
   parameter int unsigned NUM_TIMERS              = 4,
   parameter int unsigned WIDTH                   = 15,
   parameter int unsigned PRESCALE                = 8,
   parameter logic [NUM_TIMERS-1:0] CASCADE_MASK  = 4'b0010,
   parameter logic [NUM_TIMERS-1:0] IRQ_MASK      = 4'b1100,
   localparam int unsigned SW                     = $clog2(NUM_TIMERS)
) (
   input  logic                  clk,
   input  logic                  rst_l,
   input  logic                  en,
   input  logic                  wr_en,
   input  logic [SW-1:0]         wr_sel,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [SW-1:0]         rd_sel,
   output logic [WIDTH-1:0]      rd_data,
   input  logic [NUM_TIMERS-1:0] irq_ack,
   output logic                  tick,
   output logic [NUM_TIMERS-1:0] overflow,
   output logic [NUM_TIMERS-1:0] irq_pending
);

   localparam int unsigned PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]         r_presc;
   logic                  r_tick;
   logic [WIDTH-1:0]      r_timer [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] r_ovf;
   logic [NUM_TIMERS-1:0] r_irq;

   logic                  w_presc_last;
   logic [NUM_TIMERS-1:0] w_inc;
   logic [NUM_TIMERS-1:0] w_wr;
   logic [NUM_TIMERS-1:0] w_wrap;

   assign w_presc_last = (r_presc == PRESC_LAST);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
      end else begin
         r_tick <= en && w_presc_last;
         if (en) begin
            r_presc <= w_presc_last ? '0 : r_presc + 1'b1;
         end
      end
   end

   // Out-of-range wr_sel never matches any index, so such writes fall through.
   always_comb begin
      w_inc  = '0;
      w_wr   = '0;
      w_wrap = '0;
      w_inc[0] = r_tick;
      for (int unsigned i = 1; i < NUM_TIMERS; i++) begin
         w_inc[i] = CASCADE_MASK[i] ? r_ovf[i-1] : r_tick;
      end
      for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
         w_wr[i]   = wr_en && (wr_sel == SW'(i));
         w_wrap[i] = w_inc[i] && (&r_timer[i]) && !w_wr[i];
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            r_timer[i] <= '0;
         end
         r_ovf <= '0;
         r_irq <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_TIMERS; i++) begin
            if (w_wr[i]) begin
               r_timer[i] <= wr_data;
            end else if (w_inc[i]) begin
               r_timer[i] <= r_timer[i] + 1'b1;
            end
         end
         r_ovf <= w_wrap;
         r_irq <= (r_ovf & IRQ_MASK) | (r_irq & ~irq_ack);
      end
   end

   always_comb begin
      rd_data = '0;
      if (32'(rd_sel) < NUM_TIMERS) begin
         rd_data = (wr_en && (wr_sel == rd_sel)) ? wr_data : r_timer[rd_sel];
      end
   end

   assign tick        = r_tick;
   assign overflow    = r_ovf;
   assign irq_pending = r_irq;

endmodule

// File: tb/tb_agc_timer_bank.sv
// Self-checking bench for agc_timer_bank: directed sequences, a read/write vector
// table and randomized traffic, all against an arithmetic reference model.
module tb_agc_timer_bank;

   localparam int N    = 4;
   localparam int W    = 15;
   localparam int P    = 8;
   localparam int MAXV = 1 << W;
   localparam logic [3:0] CASC = 4'b0010;
   localparam logic [3:0] IRQM = 4'b1100;

   logic          clk = 1'b0;
   logic          rst_l;
   logic          en;
   logic          wr_en;
   logic [1:0]    wr_sel;
   logic [W-1:0]  wr_data;
   logic [1:0]    rd_sel;
   logic [W-1:0]  rd_data;
   logic [N-1:0]  irq_ack;
   logic          tick;
   logic [N-1:0]  overflow;
   logic [N-1:0]  irq_pending;

   agc_timer_bank #(
      .NUM_TIMERS  (N),
      .WIDTH       (W),
      .PRESCALE    (P),
      .CASCADE_MASK(CASC),
      .IRQ_MASK    (IRQM)
   ) dut (
      .clk        (clk),
      .rst_l      (rst_l),
      .en         (en),
      .wr_en      (wr_en),
      .wr_sel     (wr_sel),
      .wr_data    (wr_data),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .irq_ack    (irq_ack),
      .tick       (tick),
      .overflow   (overflow),
      .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: enabled-cycle count, timer values as plain integers
   int         m_en_cycles;
   int         m_timer [N];
   logic [3:0] m_ovf;
   logic [3:0] m_pend;
   bit         m_tick;

   typedef struct {
      bit we;
      int ws;
      int wd;
      int rs;
      int exp_rd;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_en_cycles = 0;
      for (int i = 0; i < N; i++) m_timer[i] = 0;
      m_ovf  = '0;
      m_pend = '0;
      m_tick = 1'b0;
   endtask

   task automatic model_step(input bit e, input bit we, input int ws, input int wd,
                             input logic [3:0] ack);
      int         nt [N];
      logic [3:0] no;
      logic [3:0] np;
      bit         ntk;
      bit         src;
      ntk = e && ((m_en_cycles % P) == P - 1);
      if (e) m_en_cycles++;
      for (int i = 0; i < N; i++) begin
         src = m_tick;
         if (i > 0 && CASC[i]) src = m_ovf[i-1];
         no[i] = 1'b0;
         nt[i] = m_timer[i];
         if (we && ws == i) begin
            nt[i] = wd & (MAXV - 1);
         end else if (src) begin
            nt[i] = m_timer[i] + 1;
            if (nt[i] == MAXV) begin
               nt[i] = 0;
               no[i] = 1'b1;
            end
         end
         np[i] = (m_ovf[i] & IRQM[i]) | (m_pend[i] & ~ack[i]);
      end
      m_timer = nt;
      m_ovf   = no;
      m_pend  = np;
      m_tick  = ntk;
   endtask

   function automatic int exp_rd(input int sel, input bit we, input int ws, input int wd);
      if (sel >= N) return 0;
      if (we && ws == sel) return wd & (MAXV - 1);
      return m_timer[sel];
   endfunction

   // One clock: drive inputs, check combinational read, clock, check registered outputs.
   task automatic step(input bit e, input bit we, input int ws, input int wd, input int rs,
                       input logic [3:0] ack);
      en      = e;
      wr_en   = we;
      wr_sel  = 2'(ws);
      wr_data = W'(wd);
      rd_sel  = 2'(rs);
      irq_ack = ack;
      #1 chk("rd_data", 32'(rd_data), 32'(exp_rd(rs, we, ws, wd)));
      @(posedge clk);
      model_step(e, we, ws, wd, ack);
      #1;
      chk("tick", 32'(tick), 32'(m_tick));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("irq_pending", 32'(irq_pending), 32'(m_pend));
   endtask

   task automatic peek(input int sel, input int exp, input string nm);
      wr_en  = 1'b0;
      rd_sel = 2'(sel);
      #1 chk(nm, 32'(rd_data), 32'(exp));
   endtask

   task automatic run_until_tick();
      for (int k = 0; k < 20 && !m_tick; k++) step(1, 0, 0, 0, 0, '0);
      if (!m_tick) chk("tick_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst_l   = 1'b0;
      en      = 1'b0;
      wr_en   = 1'b0;
      irq_ack = '0;
      #1;
      chk("rst_tick", 32'(tick), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_irq", 32'(irq_pending), 0);
      model_reset();
      for (int i = 0; i < N; i++) peek(i, 0, "rst_timer");
      #1 rst_l = 1'b1;
   endtask

   initial begin
      int cnt;
      int t0;
      bit e;
      bit we;
      int wd;

      tbl[0] = '{1, 0, 'h1234, 0, 'h1234};
      tbl[1] = '{0, 0, 0,      0, 'h1234};
      tbl[2] = '{1, 1, 'h7FFF, 0, 'h1234};
      tbl[3] = '{1, 2, 'h0055, 2, 'h0055};
      tbl[4] = '{0, 0, 0,      1, 'h7FFF};
      tbl[5] = '{1, 3, 'h2AAA, 1, 'h7FFF};
      tbl[6] = '{0, 0, 0,      3, 'h2AAA};
      tbl[7] = '{1, 3, 'h0001, 3, 'h0001};
      tbl[8] = '{0, 0, 0,      2, 'h0055};

      rst_l = 1'b0; en = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
      rd_sel = '0; irq_ack = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 do_reset();

      // Read/write forwarding vectors, prescaler idle
      for (int i = 0; i < 9; i++) begin
         en = 1'b0; wr_en = tbl[i].we; wr_sel = 2'(tbl[i].ws);
         wr_data = W'(tbl[i].wd); rd_sel = 2'(tbl[i].rs); irq_ack = '0;
         #1 chk("tbl_rd", 32'(rd_data), 32'(tbl[i].exp_rd));
         step(0, tbl[i].we, tbl[i].ws, tbl[i].wd, tbl[i].rs, '0);
      end

      // 1: 24 enabled cycles give three ticks
      @(posedge clk); #1 do_reset();
      cnt = 0;
      for (int i = 0; i < 24; i++) begin
         step(1, 0, 0, 0, 0, '0);
         if (tick) cnt++;
      end
      chk("t1_ticks", cnt, 3);
      step(0, 0, 0, 0, 0, '0);
      peek(0, 3, "t1_timer0");
      peek(1, 0, "t1_timer1");

      // 2: timer0 wrap cascades into timer1, masked irq
      step(0, 1, 0, 'h7FFF, 0, '0);
      peek(0, 'h7FFF, "t2_written");
      run_until_tick();
      step(0, 0, 0, 0, 0, '0);
      peek(0, 0, "t2_timer0_wrap");
      chk("t2_ovf0", 32'(overflow), 32'h1);
      step(0, 0, 0, 0, 0, '0);
      peek(1, 1, "t2_timer1_inc");
      chk("t2_ovf_clear", 32'(overflow), 0);
      chk("t2_irq_none", 32'(irq_pending), 0);

      // 3: timer2 irq set, set-beats-ack, ack alone, ack when idle
      step(0, 1, 2, 'h7FFF, 0, '0);
      run_until_tick();
      step(0, 0, 0, 0, 0, '0);
      peek(2, 0, "t3_timer2_wrap");
      chk("t3_ovf2", 32'(overflow), 32'h4);
      step(0, 0, 0, 0, 0, '0);
      chk("t3_irq_set", 32'(irq_pending), 32'h4);
      step(0, 1, 2, 'h7FFF, 0, '0);
      run_until_tick();
      step(0, 0, 0, 0, 0, '0);
      chk("t3_ovf2_again", 32'(overflow), 32'h4);
      step(0, 0, 0, 0, 0, 4'b0100);
      chk("t3_set_beats_ack", 32'(irq_pending), 32'h4);
      step(0, 0, 0, 0, 0, 4'b0100);
      chk("t3_ack_clears", 32'(irq_pending), 0);
      step(0, 0, 0, 0, 0, 4'b1111);
      chk("t3_ack_idle", 32'(irq_pending), 0);

      // 4: write in a tick cycle beats the increment, read forwarded
      run_until_tick();
      en = 1'b0; wr_en = 1'b1; wr_sel = 2'd0; wr_data = 15'h1234; rd_sel = 2'd0; irq_ack = '0;
      #1 chk("t4_fwd", 32'(rd_data), 32'h1234);
      step(0, 1, 0, 'h1234, 0, '0);
      peek(0, 'h1234, "t4_no_inc");

      // 5: freeze mid-count, resume from the held prescaler value
      repeat (3) step(1, 0, 0, 0, 0, '0);
      t0 = m_timer[0];
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0, 0, '0);
         if (tick) cnt++;
      end
      chk("t5_frozen_ticks", cnt, 0);
      peek(0, t0, "t5_frozen_timer0");
      cnt = 0;
      for (int k = 1; k <= 16 && cnt == 0; k++) begin
         step(1, 0, 0, 0, 0, '0);
         if (tick) cnt = k;
      end
      chk("t5_resume_latency", cnt, 5);

      // 6: async reset with a pending irq, counting restarts from zero
      step(0, 1, 3, 'h7FFF, 0, '0);
      run_until_tick();
      step(0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 0, '0);
      chk("t6_irq3", 32'(irq_pending), 32'h8);
      repeat (3) step(1, 0, 0, 0, 0, '0);
      do_reset();
      cnt = 0;
      for (int k = 1; k <= 16 && cnt == 0; k++) begin
         step(1, 0, 0, 0, 0, '0);
         if (tick) cnt = k;
      end
      chk("t6_restart_latency", cnt, P);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         e  = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 7) == 0);
         wd = $urandom_range(0, 1) ? int'($urandom_range(32'h7FF8, 32'h7FFF))
                                   : int'($urandom & 32'h7FFF);
         step(e, we, int'($urandom_range(0, 3)), wd, int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
